// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down event counter with a time-multiplexed, anti-ghosting
// display scanner feeding a common-anode BCD-to-seven-segment decoder.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    count_en,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    wrap,
  output logic                    load_err
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_DARK  = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]          ALL_NINE = {NUM_DIGITS{4'h9}};
  localparam logic [W-1:0]          ALL_ZERO = {W{1'b0}};

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Out-of-range nibbles are forced to 0 so no digit ever leaves 0..9.
  function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_has_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  function automatic logic [3:0] digit_at(input logic [W-1:0] v, input logic [IW-1:0] sel);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(sel) == i) begin
        d = v[4*i +: 4];
      end
    end
    return d;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are 0.
  function automatic logic lead_zero(input logic [W-1:0] v, input logic [IW-1:0] sel);
    logic blank;
    blank = (LZ_BLANK != 0) && (sel != {IW{1'b0}});
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(sel)) && (v[4*i +: 4] != 4'd0)) begin
        blank = 1'b0;
      end
    end
    return blank;
  endfunction

  // Count path: clear > load > count strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= ALL_ZERO;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (clear) begin
      value    <= ALL_ZERO;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      value    <= bcd_sanitize(load_val);
      wrap     <= 1'b0;
      load_err <= bcd_has_bad(load_val);
    end else if (count_en) begin
      load_err <= 1'b0;
      if (up_dn) begin
        value <= bcd_inc(value);
        wrap  <= (value == ALL_NINE);
      end else begin
        value <= bcd_dec(value);
        wrap  <= (value == ALL_ZERO);
      end
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

  // Scanner: prescaler==0 is the dark slot; digit and blanking latch on leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= {PW{1'b0}};
      idx      <= {IW{1'b0}};
      bcd_out  <= 4'd0;
      digit_an <= AN_DARK;
    end else if (presc == PRE_LAST) begin
      presc    <= {PW{1'b0}};
      idx      <= (idx == IDX_LAST) ? {IW{1'b0}} : idx + IW'(1);
      digit_an <= AN_DARK;
    end else begin
      presc <= presc + PW'(1);
      if (presc == {PW{1'b0}}) begin
        bcd_out  <= digit_at(value, idx);
        digit_an <= lead_zero(value, idx) ? AN_DARK : ~(AN_ONE << idx);
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: decimal-integer reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_bcd_scan_counter;

  localparam int N    = 4;
  localparam int SD   = 4;
  localparam int MAXV = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          count_en = 1'b0;
  logic          up_dn = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_val = 16'h0000;
  logic [15:0]   value;
  logic [3:0]    bcd_out;
  logic [3:0]    digit_an;
  logic          wrap;
  logic          load_err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (decimal count, scan time since reset release)
  int   m_val;
  int   m_t;
  int   m_bcd;
  logic m_blank;
  logic m_wrap;
  logic m_lerr;

  bcd_scan_counter #(.NUM_DIGITS(N), .SCAN_DIV(SD), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .count_en(count_en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val), .value(value),
    .bcd_out(bcd_out), .digit_an(digit_an), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int j = 0; j < e; j++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = 16'h0000;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_num(input logic [15:0] lv);
    int s;
    s = 0;
    for (int i = 0; i < N; i++)
      if (lv[4*i +: 4] <= 4'd9) s = s + int'(lv[4*i +: 4]) * pow10(i);
    return s;
  endfunction

  function automatic logic load_bad(input logic [15:0] lv);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++)
      if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // Reference model advanced on every active clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val <= 0; m_t <= 0; m_bcd <= 0; m_blank <= 1'b0; m_wrap <= 1'b0; m_lerr <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_t % SD == 0) begin
        m_bcd   <= (m_val / pow10((m_t / SD) % N)) % 10;
        m_blank <= ((m_t / SD) % N > 0) && (m_val < pow10((m_t / SD) % N));
      end
      m_wrap <= 1'b0;
      m_lerr <= 1'b0;
      if (clear) begin
        m_val <= 0;
      end else if (load) begin
        m_val  <= load_num(load_val);
        m_lerr <= load_bad(load_val);
      end else if (count_en) begin
        if (up_dn) begin
          m_val  <= (m_val + 1) % MAXV;
          m_wrap <= (m_val == MAXV - 1);
        end else begin
          m_val  <= (m_val + MAXV - 1) % MAXV;
          m_wrap <= (m_val == 0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [3:0] exp_an;
    int slot;
    slot = (m_t / SD) % N;
    if ((m_t % SD == 0) || m_blank) exp_an = 4'hF;
    else exp_an = ~(4'b0001 << slot);
    chk("model_value", 32'(value), 32'(to_bcd(m_val)));
    chk("model_bcd_out", 32'(bcd_out), 32'(m_bcd));
    chk("model_digit_an", 32'(digit_an), 32'(exp_an));
    chk("model_wrap", 32'(wrap), 32'(m_wrap));
    chk("model_load_err", 32'(load_err), 32'(m_lerr));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      compare_model();
    end
  endtask

  task automatic wait_phase(input int modulus, input int phase, input string name);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!hit && (m_t % modulus == phase)) hit = 1'b1;
      if (!hit) step(1);
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  logic [3:0] lit_an [4];
  logic [3:0] lit_bcd [4];

  initial begin
    lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    lit_bcd = '{4'd5, 4'd0, 4'd3, 4'd0};

    // 1: reset and release
    step(2);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_an", 32'(digit_an), 32'hF);
    rst_n = 1'b1;
    chk("release_dark", 32'(digit_an), 32'hF);
    step(1);
    chk("first_show_an", 32'(digit_an), 32'hE);
    chk("first_show_bcd", 32'(bcd_out), 32'h0);
    step(4);
    chk("lz_slot1_dark", 32'(digit_an), 32'hF);

    // 2: load 9998, two up strobes
    load = 1'b1; load_val = 16'h9998;
    step(1);
    load = 1'b0;
    chk("load_9998", 32'(value), 32'h9998);
    count_en = 1'b1; up_dn = 1'b1;
    step(1);
    chk("up_9999", 32'(value), 32'h9999);
    chk("up_9999_nowrap", 32'(wrap), 32'h0);
    step(1);
    count_en = 1'b0;
    chk("up_wrap_value", 32'(value), 32'h0000);
    chk("up_wrap_pulse", 32'(wrap), 32'h1);
    step(1);
    chk("up_wrap_ends", 32'(wrap), 32'h0);

    // 3: down from 0, then bad load
    count_en = 1'b1; up_dn = 1'b0;
    step(1);
    count_en = 1'b0;
    chk("down_value", 32'(value), 32'h9999);
    chk("down_wrap", 32'(wrap), 32'h1);
    load = 1'b1; load_val = 16'h12AF;
    step(1);
    load = 1'b0;
    chk("bad_load_value", 32'(value), 32'h1200);
    chk("bad_load_err", 32'(load_err), 32'h1);
    step(1);
    chk("load_err_ends", 32'(load_err), 32'h0);

    // 4: scan pattern for 0305
    load = 1'b1; load_val = 16'h0305;
    step(1);
    load = 1'b0;
    wait_phase(N * SD, 0, "scan_align");
    for (int s = 0; s < N; s++) begin
      step(1);
      chk("scan_an", 32'(digit_an), 32'(lit_an[s]));
      chk("scan_bcd", 32'(bcd_out), 32'(lit_bcd[s]));
      step(SD - 1);
      chk("scan_dead", 32'(digit_an), 32'hF);
    end

    // 5: clear + load + count together
    load = 1'b1; load_val = 16'h0042;
    step(1);
    clear = 1'b1; load_val = 16'h00AF; count_en = 1'b1; up_dn = 1'b1;
    step(1);
    clear = 1'b0; load = 1'b0; count_en = 1'b0;
    chk("clr_all_value", 32'(value), 32'h0);
    chk("clr_all_wrap", 32'(wrap), 32'h0);
    chk("clr_all_lerr", 32'(load_err), 32'h0);

    // 6: reset mid-SHOW
    load = 1'b1; load_val = 16'h0042;
    step(1);
    load = 1'b0;
    wait_phase(N * SD, 2, "mid_show_align");
    chk("mid_show_lit", 32'(digit_an), 32'hE);
    #1 rst_n = 1'b0;
    #1;
    chk("async_dark", 32'(digit_an), 32'hF);
    chk("async_value", 32'(value), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("resume_idx0_an", 32'(digit_an), 32'hE);
    chk("resume_idx0_bcd", 32'(bcd_out), 32'h0);

    // mixed counting traffic against the model
    for (int k = 0; k < 120; k++) begin
      count_en = 1'($urandom_range(0, 1));
      up_dn    = (k < 60) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      load     = (k % 37 == 5);
      load_val = 16'h9990 + 16'($urandom_range(0, 15));
      clear    = (k == 100);
      step(1);
    end
    count_en = 1'b0; load = 1'b0; clear = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
